interrupt_controller: RTL and testbench

- Consumer end of the timer's `timeout` line and of other peripheral event lines.
- Converts level events into latched, maskable, prioritised interrupt requests to the CPU core.
- Uses a request/acknowledge/done handshake with the core and supplies a handler vector.
- The CPU programs the mask over the shared DATA bus and reads status back, in the same style as the timer register.

---
 rtl/interrupt_controller.sv | 121 ++++++++++++
 tb/tb_interrupt_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - latched, maskable, prioritised interrupt controller
// Rising edges latch pending; lowest-index unmasked pending source is requested via irq/ack/done.
module interrupt_controller #(
  parameter int          NUM_SRC  = 4,
  parameter logic [15:0] VEC_BASE = 16'h00F0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [15:0]        DATA,
  input  logic               mask_in,
  output logic [15:0]        REG_OUT_INTC,
  output logic               irq,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack,
  input  logic               irq_done,
  output logic               in_service
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] prev_src;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] clr;
  logic [2:0]         active_id;
  logic [2:0]         win_id;
  logic               win_vld;
  logic               ack_take;
  logic [7:0]         mask_pad;
  logic [7:0]         pend_pad;
  logic               unused_data;

  assign rise        = irq_src & ~prev_src;
  assign req         = pending & mask;
  assign ack_take    = (state == ST_REQ) && irq_ack;
  assign unused_data = ^DATA;

  // Scan downwards so the lowest requesting index is the last one written.
  always_comb begin
    win_id  = 3'd0;
    win_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_id  = 3'(i);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = ack_take && (active_id == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_src <= '0;
      pending  <= '0;
      mask     <= '0;
    end else begin
      prev_src <= irq_src;
      // A new edge in the ack cycle must survive the clear.
      pending  <= (pending & ~clr) | rise;
      if (mask_in) begin
        mask <= DATA[NUM_SRC-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      active_id  <= 3'd0;
      irq        <= 1'b0;
      in_service <= 1'b0;
      irq_vector <= VEC_BASE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            active_id  <= win_id;
            irq_vector <= VEC_BASE + {13'd0, win_id};
            irq        <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            irq        <= 1'b0;
            in_service <= 1'b1;
            state      <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (irq_done) begin
            in_service <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mask_pad                = '0;
    pend_pad                = '0;
    mask_pad[NUM_SRC-1:0]   = mask;
    pend_pad[NUM_SRC-1:0]   = pending;
    REG_OUT_INTC            = {mask_pad, pend_pad};
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed and randomized check against a behavioural model
module tb_interrupt_controller;

  localparam logic [15:0] VB = 16'h00F0;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_src;
  logic [15:0] DATA;
  logic        mask_in;
  logic [15:0] REG_OUT_INTC;
  logic        irq;
  logic [15:0] irq_vector;
  logic        irq_ack;
  logic        irq_done;
  logic        in_service;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller #(.NUM_SRC(4), .VEC_BASE(VB)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .DATA(DATA), .mask_in(mask_in),
    .REG_OUT_INTC(REG_OUT_INTC), .irq(irq), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .irq_done(irq_done), .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Reference: which source is being handled and what the core has seen so far.
  bit          m_src_prev [4];
  bit          m_pend [4];
  bit          m_en [4];
  bit          m_waiting_ack;
  bit          m_in_handler;
  int          m_serving;
  logic [15:0] m_vec;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_src_prev[i] = 0; m_pend[i] = 0; m_en[i] = 0;
    end
    m_waiting_ack = 0; m_in_handler = 0; m_serving = 0; m_vec = VB;
  endtask

  task automatic model_step();
    int  cleared;
    bit  busy;
    cleared = -1;
    busy = m_waiting_ack || m_in_handler;
    if (!busy) begin
      for (int i = 3; i >= 0; i--)
        if (m_pend[i] && m_en[i]) m_serving = i;
      for (int i = 0; i < 4; i++)
        if (m_pend[i] && m_en[i]) begin
          m_waiting_ack = 1;
          m_vec = VB + 16'(m_serving);
        end
    end else if (m_waiting_ack) begin
      if (irq_ack) begin
        m_waiting_ack = 0; m_in_handler = 1; cleared = m_serving;
      end
    end else if (irq_done) begin
      m_in_handler = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (i == cleared) m_pend[i] = 0;
      if (irq_src[i] && !m_src_prev[i]) m_pend[i] = 1;
      if (mask_in) m_en[i] = DATA[i];
      m_src_prev[i] = irq_src[i];
    end
  endtask

  function automatic logic [15:0] model_reg();
    logic [15:0] r;
    r = 16'h0;
    for (int i = 0; i < 4; i++) begin
      r[8+i] = m_en[i];
      r[i]   = m_pend[i];
    end
    return r;
  endfunction

  task automatic compare_all();
    check_val("irq", 16'(irq), 16'(m_waiting_ack));
    check_val("in_service", 16'(in_service), 16'(m_in_handler));
    check_val("irq_vector", irq_vector, m_vec);
    check_val("reg_out", REG_OUT_INTC, model_reg());
  endtask

  task automatic cycle(input logic [3:0] s, input logic [15:0] d, input logic ml,
                       input logic a, input logic dn);
    irq_src = s; DATA = d; mask_in = ml; irq_ack = a; irq_done = dn;
    @(posedge clk);
    if (!reset) model_reset(); else model_step();
    #1;
    compare_all();
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_val({tag, "_irq"}, 16'(irq), 16'h0);
    check_val({tag, "_insvc"}, 16'(in_service), 16'h0);
    check_val({tag, "_reg"}, REG_OUT_INTC, 16'h0);
    check_val({tag, "_vec"}, irq_vector, VB);
  endtask

  initial begin
    logic [3:0] src;
    logic [3:0] flip;
    int         rises;
    logic       last_irq;
    reset = 1'b0; irq_src = '0; DATA = '0; mask_in = 0; irq_ack = 0; irq_done = 0;
    model_reset();
    #12;
    compare_all();
    check_val("rst_reg", REG_OUT_INTC, 16'h0000);
    #4 reset = 1'b1;

    // Single source, masked in first.
    cycle(4'h0, 16'h0001, 1, 0, 0);
    cycle(4'h1, 16'h0000, 0, 0, 0);
    check_val("tp1_reg_pend", REG_OUT_INTC, 16'h0101);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp1_irq", 16'(irq), 16'h1);
    check_val("tp1_vec", irq_vector, 16'h00F0);
    cycle(4'h0, 16'h0000, 0, 1, 0);
    check_val("tp1_ack_irq", 16'(irq), 16'h0);
    check_val("tp1_reg_ack", REG_OUT_INTC, 16'h0100);
    cycle(4'h0, 16'h0000, 0, 0, 1);

    // Masked source latches but does not request until unmasked.
    cycle(4'h0, 16'h0000, 1, 0, 0);
    cycle(4'h4, 16'h0000, 0, 0, 0);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp3_noirq", 16'(irq), 16'h0);
    check_val("tp3_reg", REG_OUT_INTC, 16'h0004);
    cycle(4'h0, 16'h0004, 1, 0, 0);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp3_irq", 16'(irq), 16'h1);
    check_val("tp3_vec", irq_vector, 16'h00F2);
    // Source 0 rises during REQ of 2; vector frozen.
    cycle(4'h1, 16'h000F, 1, 0, 0);
    cycle(4'h1, 16'h0000, 0, 0, 0);
    check_val("tp5_frozen", irq_vector, 16'h00F2);
    cycle(4'h0, 16'h0000, 0, 1, 0);
    cycle(4'h0, 16'h0000, 0, 0, 1);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp5_src0_vec", irq_vector, 16'h00F0);
    // Rise of source 2 in the ack cycle keeps pending[2].
    cycle(4'h4, 16'h0000, 0, 1, 0);
    check_val("tp5_set_wins", REG_OUT_INTC & 16'h0004, 16'h0004);
    cycle(4'h0, 16'h0000, 0, 0, 1);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp5_rereq", irq_vector, 16'h00F2);
    cycle(4'h0, 16'h0000, 0, 1, 0);
    cycle(4'h0, 16'h0000, 0, 0, 1);

    // Simultaneous sources 3 and 1.
    cycle(4'hA, 16'h0000, 0, 0, 0);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp4_first", irq_vector, 16'h00F1);
    cycle(4'h0, 16'h0000, 0, 1, 1);
    check_val("tp4_ack_only", 16'(in_service), 16'h1);
    cycle(4'h0, 16'h0000, 0, 0, 1);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    check_val("tp4_second", irq_vector, 16'h00F3);
    cycle(4'h0, 16'h0000, 0, 1, 0);
    cycle(4'h0, 16'h0000, 0, 0, 1);

    // Held source yields exactly one request.
    rises = 0; last_irq = irq;
    for (int n = 0; n < 20; n++) begin
      cycle(4'h1, 16'h0000, 0, m_waiting_ack, m_in_handler);
      if (irq && !last_irq) rises++;
      last_irq = irq;
    end
    check_val("hold_one_irq", 16'(rises), 16'd1);
    check_val("hold_pend0", REG_OUT_INTC & 16'h0001, 16'h0000);
    cycle(4'h0, 16'h0000, 0, 0, 0);

    // Async reset mid-SERVICE; done pulses afterwards are ignored.
    cycle(4'h2, 16'h0000, 0, 0, 0);
    cycle(4'h0, 16'h0000, 0, 0, 0);
    cycle(4'h0, 16'h0000, 0, 1, 0);
    check_val("tp6_in_svc", 16'(in_service), 16'h1);
    async_reset_check("tp6");
    cycle(4'h0, 16'h0000, 0, 0, 1);
    reset = 1'b1;
    cycle(4'h0, 16'h0000, 0, 0, 1);
    check_val("tp6_done_ign", 16'(in_service), 16'h0);

    // Randomized traffic with occasional mid-cycle resets.
    src = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      flip = '0;
      for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(4) == 0);
      src = src ^ flip;
      cycle(src, 16'($urandom), ($urandom_range(15) == 0),
            m_waiting_ack ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0),
            m_in_handler  ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0));
      if (n % 500 == 499) begin
        async_reset_check("rnd_rst");
        cycle(src, 16'h0000, 0, 0, 1);
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
